// File: rtl/itch_pkg.sv
// Shared types for the ITCH collector: message type tags, field widths and the unified record.
package itch_pkg;

  localparam int REF_W = 64;
  localparam int SHR_W = 32;
  localparam int PRC_W = 32;
  localparam int SYM_W = 64;
  localparam int MID_W = 64;
  localparam int TS_W  = 32;

  typedef enum logic [2:0] {
    MSG_NONE    = 3'd0,
    MSG_ADD     = 3'd1,
    MSG_CANCEL  = 3'd2,
    MSG_DELETE  = 3'd3,
    MSG_REPLACE = 3'd4,
    MSG_EXEC    = 3'd5,
    MSG_TRADE   = 3'd6
  } msg_type_e;

  typedef struct packed {
    msg_type_e        msg_type;
    logic [REF_W-1:0] order_ref;
    logic [REF_W-1:0] new_order_ref;
    logic             side;
    logic [SHR_W-1:0] shares;
    logic [PRC_W-1:0] price;
    logic [SYM_W-1:0] stock_symbol;
    logic [MID_W-1:0] match_id;
    logic [TS_W-1:0]  timestamp;
  } itch_rec_t;

endpackage

// File: rtl/itch_msg_collector_if.sv
// Record output bus toward the order-book stage, valid/ready handshake.
interface itch_msg_collector_if;
  import itch_pkg::*;

  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_type;
  logic [REF_W-1:0] out_order_ref;
  logic [REF_W-1:0] out_new_order_ref;
  logic [MID_W-1:0] out_match_id;
  logic [SYM_W-1:0] out_stock_symbol;
  logic [SHR_W-1:0] out_shares;
  logic [PRC_W-1:0] out_price;
  logic [TS_W-1:0]  out_timestamp;
  logic             out_side;

  modport master (
    output out_valid, out_type, out_order_ref, out_new_order_ref, out_match_id,
           out_stock_symbol, out_shares, out_price, out_timestamp, out_side,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_type, out_order_ref, out_new_order_ref, out_match_id,
           out_stock_symbol, out_shares, out_price, out_timestamp, out_side,
    output out_ready
  );
endinterface

// File: rtl/itch_rec_fifo.sv
// Synchronous FIFO of itch_rec_t; a pop in the same cycle frees room for a push when full.
// Head is read straight from storage, so it is stable until popped; storage clears on reset.
module itch_rec_fifo
  import itch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  itch_rec_t                push_dat,
  input  logic                     pop,
  output itch_rec_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  itch_rec_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/itch_msg_collector.sv
// Picks the winning ITCH decoder pulse, packs it into a typed record and queues it for the book.
// ITCH_STATS_EN adds per-type popped-record counters type_count_0..type_count_5.
module itch_msg_collector
  import itch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_internal_valid,
  input  logic             add_packet_invalid,
  input  logic [REF_W-1:0] add_order_ref,
  input  logic             add_side,
  input  logic [SHR_W-1:0] add_shares,
  input  logic [PRC_W-1:0] add_price,
  input  logic [SYM_W-1:0] add_stock_symbol,
  input  logic             cancel_internal_valid,
  input  logic             cancel_packet_invalid,
  input  logic [REF_W-1:0] cancel_order_ref,
  input  logic [SHR_W-1:0] cancel_canceled_shares,
  input  logic             delete_internal_valid,
  input  logic             delete_packet_invalid,
  input  logic [REF_W-1:0] delete_order_ref,
  input  logic             replace_internal_valid,
  input  logic             replace_packet_invalid,
  input  logic [REF_W-1:0] replace_old_order_ref,
  input  logic [REF_W-1:0] replace_new_order_ref,
  input  logic [SHR_W-1:0] replace_shares,
  input  logic [PRC_W-1:0] replace_price,
  input  logic             exec_internal_valid,
  input  logic             exec_packet_invalid,
  input  logic [REF_W-1:0] exec_order_ref,
  input  logic [SHR_W-1:0] exec_shares,
  input  logic [MID_W-1:0] exec_match_id,
  input  logic [TS_W-1:0]  exec_timestamp,
  input  logic             trade_internal_valid,
  input  logic             trade_packet_invalid,
  input  logic [REF_W-1:0] trade_order_ref,
  input  logic [SHR_W-1:0] trade_shares,
  input  logic [MID_W-1:0] trade_match_id,
  input  logic [SYM_W-1:0] trade_stock_symbol,
  input  logic [PRC_W-1:0] trade_price,
  input  logic [TS_W-1:0]  trade_timestamp,
  itch_msg_collector_if.master rec_bus,
  output logic             multi_hit,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] invalid_count
`ifdef ITCH_STATS_EN
  ,
  output logic [CNT_W-1:0] type_count_0,
  output logic [CNT_W-1:0] type_count_1,
  output logic [CNT_W-1:0] type_count_2,
  output logic [CNT_W-1:0] type_count_3,
  output logic [CNT_W-1:0] type_count_4,
  output logic [CNT_W-1:0] type_count_5
`endif
);

  itch_rec_t              rec;
  itch_rec_t              head;
  logic                   sel_vld;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   drop;
  logic [5:0]             hits;
  logic [5:0]             inv_bits;
  logic [2:0]             n_inv;
  logic [CNT_W:0]         inv_sum;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   unused_fifo;

  assign hits     = {add_internal_valid, cancel_internal_valid, delete_internal_valid,
                     replace_internal_valid, exec_internal_valid, trade_internal_valid};
  assign inv_bits = {add_packet_invalid, cancel_packet_invalid, delete_packet_invalid,
                     replace_packet_invalid, exec_packet_invalid, trade_packet_invalid};
  assign n_inv    = 3'($countones(inv_bits));
  assign inv_sum  = {1'b0, invalid_count} + (CNT_W+1)'(n_inv);

  // Priority chain doubles as the packer: fields a type does not carry stay at the zero default.
  always_comb begin
    rec     = '0;
    sel_vld = 1'b1;
    if (add_internal_valid) begin
      rec.msg_type     = MSG_ADD;
      rec.order_ref    = add_order_ref;
      rec.side         = add_side;
      rec.shares       = add_shares;
      rec.price        = add_price;
      rec.stock_symbol = add_stock_symbol;
    end else if (cancel_internal_valid) begin
      rec.msg_type  = MSG_CANCEL;
      rec.order_ref = cancel_order_ref;
      rec.shares    = cancel_canceled_shares;
    end else if (delete_internal_valid) begin
      rec.msg_type  = MSG_DELETE;
      rec.order_ref = delete_order_ref;
    end else if (replace_internal_valid) begin
      rec.msg_type      = MSG_REPLACE;
      rec.order_ref     = replace_old_order_ref;
      rec.new_order_ref = replace_new_order_ref;
      rec.shares        = replace_shares;
      rec.price         = replace_price;
    end else if (exec_internal_valid) begin
      rec.msg_type  = MSG_EXEC;
      rec.order_ref = exec_order_ref;
      rec.shares    = exec_shares;
      rec.match_id  = exec_match_id;
      rec.timestamp = exec_timestamp;
    end else if (trade_internal_valid) begin
      rec.msg_type     = MSG_TRADE;
      rec.order_ref    = trade_order_ref;
      rec.shares       = trade_shares;
      rec.match_id     = trade_match_id;
      rec.stock_symbol = trade_stock_symbol;
      rec.price        = trade_price;
      rec.timestamp    = trade_timestamp;
    end else begin
      sel_vld = 1'b0;
    end
  end

  itch_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (sel_vld),
    .push_dat (rec),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  assign unused_fifo = ^fifo_count;
  assign pop         = rec_bus.out_valid && rec_bus.out_ready;
  assign drop        = sel_vld && full && !pop;

  assign rec_bus.out_valid         = !empty;
  assign rec_bus.out_type          = head.msg_type;
  assign rec_bus.out_order_ref     = head.order_ref;
  assign rec_bus.out_new_order_ref = head.new_order_ref;
  assign rec_bus.out_match_id      = head.match_id;
  assign rec_bus.out_stock_symbol  = head.stock_symbol;
  assign rec_bus.out_shares        = head.shares;
  assign rec_bus.out_price         = head.price;
  assign rec_bus.out_timestamp     = head.timestamp;
  assign rec_bus.out_side          = head.side;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multi_hit     <= 1'b0;
      drop_count    <= '0;
      invalid_count <= '0;
    end else begin
      multi_hit     <= |(hits & (hits - 6'd1));
      if (drop && !(&drop_count)) drop_count <= drop_count + CNT_W'(1);
      invalid_count <= inv_sum[CNT_W] ? '1 : inv_sum[CNT_W-1:0];
    end
  end

`ifdef ITCH_STATS_EN
  logic [CNT_W-1:0] type_cnt [6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) type_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (pop && head.msg_type == msg_type_e'(i + 1) && !(&type_cnt[i]))
          type_cnt[i] <= type_cnt[i] + CNT_W'(1);
    end
  end

  assign type_count_0 = type_cnt[0];
  assign type_count_1 = type_cnt[1];
  assign type_count_2 = type_cnt[2];
  assign type_count_3 = type_cnt[3];
  assign type_count_4 = type_cnt[4];
  assign type_count_5 = type_cnt[5];
`endif

endmodule

// File: tb/tb_itch_msg_collector.sv
// Directed bench for itch_msg_collector: hand-computed expectations checked with immediate assertions.
module tb_itch_msg_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        add_internal_valid, add_packet_invalid, add_side;
  logic [63:0] add_order_ref, add_stock_symbol;
  logic [31:0] add_shares, add_price;
  logic        cancel_internal_valid, cancel_packet_invalid;
  logic [63:0] cancel_order_ref;
  logic [31:0] cancel_canceled_shares;
  logic        delete_internal_valid, delete_packet_invalid;
  logic [63:0] delete_order_ref;
  logic        replace_internal_valid, replace_packet_invalid;
  logic [63:0] replace_old_order_ref, replace_new_order_ref;
  logic [31:0] replace_shares, replace_price;
  logic        exec_internal_valid, exec_packet_invalid;
  logic [63:0] exec_order_ref, exec_match_id;
  logic [31:0] exec_shares, exec_timestamp;
  logic        trade_internal_valid, trade_packet_invalid;
  logic [63:0] trade_order_ref, trade_match_id, trade_stock_symbol;
  logic [31:0] trade_shares, trade_price, trade_timestamp;
  logic        multi_hit;
  logic [15:0] drop_count, invalid_count;
`ifdef ITCH_STATS_EN
  logic [15:0] type_count_0, type_count_1, type_count_2, type_count_3, type_count_4, type_count_5;
`endif

  itch_msg_collector_if bus ();

  itch_msg_collector #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .add_internal_valid(add_internal_valid), .add_packet_invalid(add_packet_invalid),
    .add_order_ref(add_order_ref), .add_side(add_side), .add_shares(add_shares),
    .add_price(add_price), .add_stock_symbol(add_stock_symbol),
    .cancel_internal_valid(cancel_internal_valid), .cancel_packet_invalid(cancel_packet_invalid),
    .cancel_order_ref(cancel_order_ref), .cancel_canceled_shares(cancel_canceled_shares),
    .delete_internal_valid(delete_internal_valid), .delete_packet_invalid(delete_packet_invalid),
    .delete_order_ref(delete_order_ref),
    .replace_internal_valid(replace_internal_valid), .replace_packet_invalid(replace_packet_invalid),
    .replace_old_order_ref(replace_old_order_ref), .replace_new_order_ref(replace_new_order_ref),
    .replace_shares(replace_shares), .replace_price(replace_price),
    .exec_internal_valid(exec_internal_valid), .exec_packet_invalid(exec_packet_invalid),
    .exec_order_ref(exec_order_ref), .exec_shares(exec_shares),
    .exec_match_id(exec_match_id), .exec_timestamp(exec_timestamp),
    .trade_internal_valid(trade_internal_valid), .trade_packet_invalid(trade_packet_invalid),
    .trade_order_ref(trade_order_ref), .trade_shares(trade_shares),
    .trade_match_id(trade_match_id), .trade_stock_symbol(trade_stock_symbol),
    .trade_price(trade_price), .trade_timestamp(trade_timestamp),
    .rec_bus(bus),
    .multi_hit(multi_hit), .drop_count(drop_count), .invalid_count(invalid_count)
`ifdef ITCH_STATS_EN
    , .type_count_0(type_count_0), .type_count_1(type_count_1), .type_count_2(type_count_2),
    .type_count_3(type_count_3), .type_count_4(type_count_4), .type_count_5(type_count_5)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    {add_internal_valid, add_packet_invalid, add_side} = '0;
    {add_order_ref, add_stock_symbol, add_shares, add_price} = '0;
    {cancel_internal_valid, cancel_packet_invalid, cancel_order_ref, cancel_canceled_shares} = '0;
    {delete_internal_valid, delete_packet_invalid, delete_order_ref} = '0;
    {replace_internal_valid, replace_packet_invalid, replace_old_order_ref} = '0;
    {replace_new_order_ref, replace_shares, replace_price} = '0;
    {exec_internal_valid, exec_packet_invalid, exec_order_ref} = '0;
    {exec_shares, exec_match_id, exec_timestamp} = '0;
    {trade_internal_valid, trade_packet_invalid, trade_order_ref, trade_shares} = '0;
    {trade_match_id, trade_stock_symbol, trade_price, trade_timestamp} = '0;
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    bus.out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_multi_hit", 64'(multi_hit), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_invalid", 64'(invalid_count), 64'd0);
    check("rst_order_ref", bus.out_order_ref, 64'd0);
    rst = 1'b0;
    step();

    // Single add pulse
    add_internal_valid = 1'b1;
    add_order_ref      = 64'h1122334455667788;
    add_side           = 1'b1;
    add_shares         = 32'd100;
    add_price          = 32'h00012345;
    add_stock_symbol   = 64'h4141504C20202020;
    step();
    clr_inputs();
    check("add_valid", 64'(bus.out_valid), 64'd1);
    check("add_type", 64'(bus.out_type), 64'd1);
    check("add_ref", bus.out_order_ref, 64'h1122334455667788);
    check("add_side", 64'(bus.out_side), 64'd1);
    check("add_shares", 64'(bus.out_shares), 64'd100);
    check("add_price", 64'(bus.out_price), 64'h00012345);
    check("add_symbol", bus.out_stock_symbol, 64'h4141504C20202020);
    check("add_match_id", bus.out_match_id, 64'd0);
    check("add_new_ref", bus.out_new_order_ref, 64'd0);
    step();
    check("add_valid_drop", 64'(bus.out_valid), 64'd0);

    // Replace pulse
    replace_internal_valid = 1'b1;
    replace_old_order_ref  = 64'd5;
    replace_new_order_ref  = 64'd6;
    replace_shares         = 32'd50;
    replace_price          = 32'd7;
    step();
    clr_inputs();
    check("rep_type", 64'(bus.out_type), 64'd4);
    check("rep_ref", bus.out_order_ref, 64'd5);
    check("rep_new_ref", bus.out_new_order_ref, 64'd6);
    check("rep_shares", 64'(bus.out_shares), 64'd50);
    check("rep_price", 64'(bus.out_price), 64'd7);
    check("rep_symbol", bus.out_stock_symbol, 64'd0);
    step();

    // Collision: add beats trade
    add_internal_valid   = 1'b1;
    add_order_ref        = 64'hA;
    trade_internal_valid = 1'b1;
    trade_order_ref      = 64'hB;
    trade_match_id       = 64'hCC;
    step();
    clr_inputs();
    check("col_type", 64'(bus.out_type), 64'd1);
    check("col_ref", bus.out_order_ref, 64'hA);
    check("col_multi_hit", 64'(multi_hit), 64'd1);
    check("col_match_id", bus.out_match_id, 64'd0);
    step();
    check("col_multi_hit_clr", 64'(multi_hit), 64'd0);
    check("col_one_rec", 64'(bus.out_valid), 64'd0);
    check("col_drop", 64'(drop_count), 64'd0);

    // Overfill with consumer stalled: 8 accepted, 2 dropped
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      delete_internal_valid = 1'b1;
      delete_order_ref      = 64'(i);
      step();
    end
    clr_inputs();
    check("full_drop", 64'(drop_count), 64'd2);
    check("full_valid", 64'(bus.out_valid), 64'd1);
    check("full_head", bus.out_order_ref, 64'd1);
    step();
    check("stall_stable_ref", bus.out_order_ref, 64'd1);
    check("stall_stable_type", 64'(bus.out_type), 64'd3);

    // Full with simultaneous pop: push accepted
    bus.out_ready          = 1'b1;
    cancel_internal_valid  = 1'b1;
    cancel_order_ref       = 64'h77;
    cancel_canceled_shares = 32'd33;
    step();
    clr_inputs();
    check("fullpop_drop", 64'(drop_count), 64'd2);
    for (int k = 2; k <= 8; k++) begin
      check("drain_valid", 64'(bus.out_valid), 64'd1);
      check("drain_type", 64'(bus.out_type), 64'd3);
      check("drain_ref", bus.out_order_ref, 64'(k));
      step();
    end
    check("cancel_type", 64'(bus.out_type), 64'd2);
    check("cancel_ref", bus.out_order_ref, 64'h77);
    check("cancel_shares", 64'(bus.out_shares), 64'd33);
    step();
    check("drained_empty", 64'(bus.out_valid), 64'd0);
`ifdef ITCH_STATS_EN
    check("stat_add", 64'(type_count_0), 64'd2);
    check("stat_cancel", 64'(type_count_1), 64'd1);
    check("stat_delete", 64'(type_count_2), 64'd8);
    check("stat_replace", 64'(type_count_3), 64'd1);
    check("stat_exec", 64'(type_count_4), 64'd0);
    check("stat_trade", 64'(type_count_5), 64'd0);
`endif

    // Exec pulse
    exec_internal_valid = 1'b1;
    exec_order_ref      = 64'd9;
    exec_shares         = 32'd4;
    exec_match_id       = 64'h55;
    exec_timestamp      = 32'h1000;
    step();
    clr_inputs();
    check("exec_type", 64'(bus.out_type), 64'd5);
    check("exec_match_id", bus.out_match_id, 64'h55);
    check("exec_ts", 64'(bus.out_timestamp), 64'h1000);
    check("exec_price", 64'(bus.out_price), 64'd0);
    step();

    // packet_invalid counting
    add_packet_invalid    = 1'b1;
    delete_packet_invalid = 1'b1;
    trade_packet_invalid  = 1'b1;
    step();
    clr_inputs();
    check("inv_three", 64'(invalid_count), 64'd3);
    {add_packet_invalid, cancel_packet_invalid, delete_packet_invalid} = 3'b111;
    {replace_packet_invalid, exec_packet_invalid, trade_packet_invalid} = 3'b111;
    step();
    clr_inputs();
    check("inv_six", 64'(invalid_count), 64'd9);
    check("inv_no_push", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset with records queued
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      delete_internal_valid = 1'b1;
      delete_order_ref      = 64'(i + 40);
      step();
    end
    clr_inputs();
    check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_drop", 64'(drop_count), 64'd0);
    check("arst_invalid", 64'(invalid_count), 64'd0);
    check("arst_type", 64'(bus.out_type), 64'd0);
    check("arst_ref", bus.out_order_ref, 64'd0);
`ifdef ITCH_STATS_EN
    check("arst_stat_add", 64'(type_count_0), 64'd0);
    check("arst_stat_delete", 64'(type_count_2), 64'd0);
`endif
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("post_rst_empty", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/itch_msg_collector.md
Name: itch_msg_collector

Overview:
- Downstream stage of the six speculative ITCH message decoders: add, cancel, delete, replace, executed, trade.
- Watches each decoder's one-cycle `*_internal_valid` pulse and selects the single winning decoder.
- Packs the winner's fields into one unified, type-tagged record and buffers it in a small FIFO.
- Presents records to the order-book stage over a valid/ready handshake; counts `packet_invalid` aborts and drops.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the drop and invalid counters; they saturate.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- add_internal_valid/add_packet_invalid  in  1/1  add decoder status.
- add_order_ref/add_side/add_shares/add_price/add_stock_symbol  in  64/1/32/32/64  add fields.
- cancel_internal_valid/cancel_packet_invalid  in  1/1  cancel status.
- cancel_order_ref/cancel_canceled_shares  in  64/32  cancel fields.
- delete_internal_valid/delete_packet_invalid/delete_order_ref  in  1/1/64  delete status and field.
- replace_internal_valid/replace_packet_invalid  in  1/1  replace status.
- replace_old_order_ref/replace_new_order_ref/replace_shares/replace_price  in  64/64/32/32  replace fields.
- exec_internal_valid/exec_packet_invalid  in  1/1  executed status.
- exec_order_ref/exec_shares/exec_match_id/exec_timestamp  in  64/32/64/32  executed fields.
- trade_internal_valid/trade_packet_invalid  in  1/1  trade status.
- trade_order_ref/trade_shares/trade_match_id/trade_stock_symbol/trade_price/trade_timestamp  in  64/32/64/64/32/32  trade fields.
- out_valid  out  1  head record valid.
- out_ready  in  1  consumer accepts head.
- out_type  out  3  message type: 1 ADD, 2 CANCEL, 3 DELETE, 4 REPLACE, 5 EXEC, 6 TRADE.
- out_order_ref/out_new_order_ref/out_match_id/out_stock_symbol  out  64 each  record fields.
- out_shares/out_price/out_timestamp  out  32 each  record fields.
- out_side  out  1  record field.
- multi_hit  out  1  one-cycle pulse: more than one internal_valid in the same cycle.
- drop_count/invalid_count  out  CNT_W  saturating counters.

Behaviour:
- Reset (async, immediate): FIFO emptied, pointers 0, out_valid=0, all out_* fields 0, multi_hit=0, counters 0. Reset mid-transfer discards all entries.
- Select: priority add>cancel>delete>replace>exec>trade. multi_hit pulses the cycle after a collision; losers are discarded and not counted as drops.
- Pack: fields the message type does not use are forced to 0.
  - replace: old_order_ref→out_order_ref; shares and price mapped directly.
  - cancel: canceled_shares→out_shares.
  - add side: 1 = sell.
- Push: when the selected valid is high, the record is written on that edge.
- Latency: out_valid rises the cycle after the push when the FIFO was empty. No combinational input→output path.
- Pop: a record is transferred on any edge where out_valid && out_ready; the next entry is shown the following cycle. out_* are driven directly from the head entry.
- Full, no pop: the push is dropped; drop_count += 1.
- Full with simultaneous pop: the push is accepted; occupancy is unchanged.
- Empty with simultaneous push: out_valid=0 that cycle; no bypass.
- Pointers wrap modulo DEPTH. Occupancy is a separate counter, 0..DEPTH.
- invalid_count increments by the number of packet_invalid bits set that cycle, 0..6.
- Both counters saturate at all-ones.
- Invariant: out_* are stable while out_valid && !out_ready.

Optional Feature:
- ITCH_STATS_EN defined:
  - Adds output ports type_count_0..type_count_5, CNT_W each, one per message type, ordered ADD..TRADE.
  - Each counter increments on pop (not push) of its type; counters saturate and are cleared by rst.
- ITCH_STATS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Package itch_pkg holds:
  - msg_type_e enum (NONE=0..TRADE=6);
  - packed struct itch_rec_t (type, order_ref, new_order_ref, side, shares, price, stock_symbol, match_id, timestamp);
  - field-width localparams.
- Sub-module itch_rec_fifo: generic sync FIFO of itch_rec_t with DEPTH parameter, full/empty/count, and the pop-frees-push-when-full rule.
- The top level does selection, packing and counting.

Test Plan:
- Single add pulse (ref=0x1122334455667788, side=1, shares=100, price=0x00012345, symbol="AAPL    "), out_ready=1 → next cycle out_valid=1, out_type=1, fields match, out_match_id=0; out_valid drops the following cycle.
- Replace pulse (old=5, new=6, shares=50, price=7) → out_type=4, out_order_ref=5, out_new_order_ref=6, out_stock_symbol=0.
- add and trade valid in the same cycle → only an ADD record is queued; multi_hit pulses once; drop_count=0.
- out_ready=0, 10 delete pulses with refs 1..10, DEPTH=8 → drop_count=2; then out_ready=1 → refs 1..8 come out in order, then out_valid=0.
- FIFO full, out_ready=1, new cancel pulse → accepted, count stays 8, drop_count unchanged.
- 3 queued records, assert rst mid-burst → out_valid=0 and counters 0 immediately without a clock edge; with ITCH_STATS_EN, type_count_* also 0.
